// File: rtl/rc_adder_error_sweeper.sv
// rc_adder_error_sweeper
//
// Drives operand pairs into an external WIDTH-bit ripple-carry adder under
// test. The adder's low bits may use approximate full-adder cells. One cycle
// after each pair is applied, the block samples the adder's combinational sum
// and compares it against the exact sum. It accumulates the absolute-error
// sum, the maximum error and the count of erroneous samples. The mean
// absolute error is err_sum / samples_done and is computed outside this block.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           one-cycle sweep request, honoured only when idle
//   abort           stops a running sweep; partial results are kept
//   mode            0 = sequential counter, 1 = Fibonacci LFSR
//   seed            first {op_b, op_a} pair, latched on an accepted start
//   num_samples     number of pairs to apply, latched on an accepted start
//   op_a, op_b      registered operands to the adder under test
//   sum_in          WIDTH+1 bit sum returned by the adder under test
//   busy, done      busy from accepted start to completion; done is a 1-cycle pulse
//   err_sum         saturating sum of absolute errors
//   err_max         largest absolute error seen
//   err_cnt         number of samples with a nonzero error
//   samples_done    number of samples evaluated
module rc_adder_error_sweeper #(
  parameter int unsigned          WIDTH = 16,
  parameter int unsigned          CNT_W = 32,
  parameter int unsigned          ACC_W = 48,
  parameter logic [2*WIDTH-1:0]   POLY  = 32'h8020_0003
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   seed,
  input  logic [CNT_W-1:0]     num_samples,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH:0]       sum_in,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     err_sum,
  output logic [WIDTH:0]       err_max,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     samples_done
);

  localparam int unsigned PW = 2 * WIDTH;
  // The accumulator adder is wide enough for both operands plus a carry, so
  // saturation also works when ACC_W is narrower than a single error value.
  localparam int unsigned SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic              mode_r;
  logic [PW-1:0]     seed_r;
  logic [CNT_W-1:0]  nsamp_r;
  logic [CNT_W-1:0]  issued;
  logic              valid;

  logic              accept;
  logic              abort_act;
  logic              issue;
  logic [PW-1:0]     pair;
  logic [PW-1:0]     pair_first;
  logic [PW-1:0]     pair_next;
  logic [WIDTH:0]    exact;
  logic [WIDTH:0]    err;
  logic [SW-1:0]     sum_ext;
  logic [ACC_W-1:0]  sum_sat;

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = (state == S_IDLE) && start;
    abort_act = abort && ((state == S_RUN) || (state == S_DRAIN));
    issue     = (state == S_RUN) && !abort;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (issued == nsamp_r - CNT_W'(1)) begin
          // This edge issues the final pair; its sample lands in DRAIN.
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: state_nx = abort ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand generation: the operand registers double as counter/LFSR state
  // ---------------------------------------------------------------------------
  always_comb begin
    pair       = {op_b, op_a};
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    pair_first = (mode_r && (seed_r == '0)) ? PW'(1) : seed_r;
    pair_next  = mode_r ? {pair[PW-2:0], ^(pair & POLY)} : pair + PW'(1);
  end

  // ---------------------------------------------------------------------------
  // Error evaluation against the currently held operands
  // ---------------------------------------------------------------------------
  always_comb begin
    exact   = {1'b0, op_a} + {1'b0, op_b};
    err     = (sum_in >= exact) ? (sum_in - exact) : (exact - sum_in);
    sum_ext = SW'(err_sum) + SW'(err);
    sum_sat = (sum_ext[SW-1:ACC_W] != '0) ? '1 : sum_ext[ACC_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r       <= 1'b0;
      seed_r       <= '0;
      nsamp_r      <= '0;
      issued       <= '0;
      valid        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_sum      <= '0;
      err_max      <= '0;
      err_cnt      <= '0;
      samples_done <= '0;
    end else begin
      // done is registered from the DONE state, so it appears one cycle
      // after DONE, aligned with the falling edge of busy.
      done <= (state == S_DONE);

      if (accept) begin
        mode_r       <= mode;
        seed_r       <= seed;
        nsamp_r      <= num_samples;
        issued       <= '0;
        busy         <= 1'b1;
        err_sum      <= '0;
        err_max      <= '0;
        err_cnt      <= '0;
        samples_done <= '0;
      end

      if ((state == S_DONE) || abort_act) begin
        busy <= 1'b0;
      end

      valid <= issue;

      if (issue) begin
        {op_b, op_a} <= (issued == '0) ? pair_first : pair_next;
        issued       <= issued + CNT_W'(1);
      end

      if (valid && !abort_act) begin
        err_sum      <= sum_sat;
        if (err > err_max) begin
          err_max <= err;
        end
        if (err != '0) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        samples_done <= samples_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rc_adder_error_sweeper.sv
module tb_rc_adder_error_sweeper;

  localparam int          K_EXACT  = 0;
  localparam int          K_APPROX = 1;
  localparam int          K_PLUS1  = 2;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam longint      CAP48    = (longint'(1) << 48) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] seed = '0;
  logic [31:0] num_samples = '0;
  logic [15:0] op_a, op_b;
  logic [16:0] sum_in;
  logic        busy, done;
  logic [47:0] err_sum;
  logic [16:0] err_max;
  logic [31:0] err_cnt, samples_done;

  // Narrow-accumulator instance fed a constant all-ones sum.
  logic [15:0] op_a2, op_b2;
  logic [16:0] sum_in2;
  logic        busy2, done2;
  logic [3:0]  err_sum2;
  logic [16:0] err_max2;
  logic [31:0] err_cnt2, samples_done2;

  int kind = K_EXACT;
  int checks = 0;
  int errors = 0;

  // Observations from the last sweep
  logic [31:0] obs_pairs[$];
  int          obs_done_edge, obs_done_pulses, obs_busy_fall;
  // Reference results
  logic [31:0] exp_pairs[$];
  longint      exp_sum, exp_max, exp_cnt;

  rc_adder_error_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .num_samples(num_samples), .op_a(op_a), .op_b(op_b),
    .sum_in(sum_in), .busy(busy), .done(done), .err_sum(err_sum),
    .err_max(err_max), .err_cnt(err_cnt), .samples_done(samples_done)
  );

  rc_adder_error_sweeper #(.ACC_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .num_samples(num_samples), .op_a(op_a2), .op_b(op_b2),
    .sum_in(sum_in2), .busy(busy2), .done(done2), .err_sum(err_sum2),
    .err_max(err_max2), .err_cnt(err_cnt2), .samples_done(samples_done2)
  );

  always #5 clk = ~clk;

  // Adder under test: exact, two approximate LSB cells, or exact+1.
  function automatic logic [16:0] adder(input int k, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic        c;
    s = '0;
    c = 1'b0;
    if (k == K_EXACT) return {1'b0, a} + {1'b0, b};
    if (k == K_PLUS1) return {1'b0, a} + {1'b0, b} + 17'd1;
    for (int i = 0; i < 16; i++) begin
      if (i < 2) begin
        s[i] = (a[i] | b[i]) & ~(a[i] & b[i] & c);
        c    = (~a[i] & ~b[i] & c) | (a[i] & b[i]);
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    s[16] = c;
    return s;
  endfunction

  always_comb sum_in = adder(kind, op_a, op_b);
  assign sum_in2 = 17'h1FFFF;

  // Reference: list of pairs and metrics computed with plain arithmetic.
  task automatic model_run(input logic m, input logic [31:0] s, input int n, input int k, input longint cap);
    logic [31:0] cur;
    longint      e;
    exp_pairs.delete();
    exp_sum = 0; exp_max = 0; exp_cnt = 0;
    cur = (m && s == 32'd0) ? 32'd1 : s;
    for (int i = 0; i < n; i++) begin
      exp_pairs.push_back(cur);
      e = longint'(adder(k, cur[15:0], cur[31:16])) - (longint'(cur[15:0]) + longint'(cur[31:16]));
      if (e < 0) e = -e;
      exp_sum = (exp_sum + e > cap) ? cap : exp_sum + e;
      if (e > exp_max) exp_max = e;
      if (e != 0) exp_cnt++;
      cur = m ? ((cur << 1) | 32'($countones(cur & POLY) % 2)) : cur + 32'd1;
    end
  endtask

  // Launch a sweep and watch a fixed window of edges after the start edge.
  task automatic do_sweep(input logic m, input logic [31:0] s, input int n,
                          input int abort_edge, input int restart_cyc);
    int cyc;
    obs_pairs.delete();
    obs_done_edge = -1; obs_done_pulses = 0; obs_busy_fall = -1;
    @(negedge clk);
    mode = m; seed = s; num_samples = n; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < n + 12) begin
      abort = (cyc == abort_edge - 1);
      start = (cyc == restart_cyc);
      @(negedge clk);
      cyc++;
      if (cyc <= n) obs_pairs.push_back({op_b, op_a});
      if (done) begin
        obs_done_pulses++;
        if (obs_done_edge < 0) obs_done_edge = cyc;
      end
      if (!busy && obs_busy_fall < 0) obs_busy_fall = cyc;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({op_a, op_b, busy, done} !== 34'd0) begin errors++;
      $display("FAIL reset_ops_flags: got %h want 0", {op_a, op_b, busy, done}); end
    checks++; if ({err_sum, err_max, err_cnt, samples_done} !== 129'd0) begin errors++;
      $display("FAIL reset_results: got %h want 0", {err_sum, err_max, err_cnt, samples_done}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_sweep;
    kind = K_EXACT;
    model_run(1'b0, 32'd0, 16, K_EXACT, CAP48);
    do_sweep(1'b0, 32'd0, 16, -1, -1);
    checks++; if ({err_sum, err_max, err_cnt} !== 97'd0) begin errors++;
      $display("FAIL exact_errors: got %0d/%0d/%0d want 0/0/0", err_sum, err_max, err_cnt); end
    checks++; if (samples_done !== 32'd16) begin errors++;
      $display("FAIL exact_samples: got %0d want 16", samples_done); end
    checks++; if (obs_done_edge !== 18 || obs_done_pulses !== 1) begin errors++;
      $display("FAIL exact_done: edge %0d pulses %0d want edge 18 pulses 1", obs_done_edge, obs_done_pulses); end
    checks++; if (obs_busy_fall !== 18) begin errors++;
      $display("FAIL exact_busy_fall: got %0d want 18", obs_busy_fall); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (obs_pairs[i] !== {16'd0, 16'(i)}) begin errors++;
        $display("FAIL exact_pair%0d: got %h want %h", i, obs_pairs[i], {16'd0, 16'(i)}); end
    end
  endtask

  task automatic test_approx;
    kind = K_APPROX;
    do_sweep(1'b0, 32'h0001_0001, 1, -1, -1);
    checks++; if (err_sum !== 48'd3 || err_max !== 17'd3) begin errors++;
      $display("FAIL approx_sum_max: got %0d/%0d want 3/3", err_sum, err_max); end
    checks++; if (err_cnt !== 32'd1 || samples_done !== 32'd1) begin errors++;
      $display("FAIL approx_cnt: got %0d/%0d want 1/1", err_cnt, samples_done); end
    checks++; if (obs_done_edge !== 3) begin errors++;
      $display("FAIL approx_done_edge: got %0d want 3", obs_done_edge); end
    do_sweep(1'b0, 32'h0000_0003, 1, -1, -1);
    checks++; if (err_cnt !== 32'd0 || err_sum !== 48'd0 || samples_done !== 32'd1) begin errors++;
      $display("FAIL approx_noerr: cnt %0d sum %0d samples %0d want 0 0 1", err_cnt, err_sum, samples_done); end
  endtask

  task automatic test_zero_samples;
    logic [31:0] ops_before;
    kind = K_PLUS1;
    do_sweep(1'b0, 32'h0000_0010, 3, -1, -1);
    ops_before = {op_b, op_a};
    do_sweep(1'b1, 32'h1234_5678, 0, -1, -1);
    checks++; if (obs_done_edge !== 1 || obs_done_pulses !== 1 || obs_busy_fall !== 1) begin errors++;
      $display("FAIL zero_done: edge %0d pulses %0d busyfall %0d want 1 1 1", obs_done_edge, obs_done_pulses, obs_busy_fall); end
    checks++; if ({err_sum, err_max, err_cnt, samples_done} !== 129'd0) begin errors++;
      $display("FAIL zero_results: got %h want 0", {err_sum, err_max, err_cnt, samples_done}); end
    checks++; if ({op_b, op_a} !== ops_before) begin errors++;
      $display("FAIL zero_ops_hold: got %h want %h", {op_b, op_a}, ops_before); end
  endtask

  task automatic test_lfsr;
    kind = K_APPROX;
    model_run(1'b1, 32'd0, 6, K_APPROX, CAP48);
    do_sweep(1'b1, 32'd0, 6, -1, -1);
    checks++; if (obs_pairs[0] !== 32'd1) begin errors++;
      $display("FAIL lfsr_first: got %h want 00000001", obs_pairs[0]); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (obs_pairs[i] !== exp_pairs[i]) begin errors++;
        $display("FAIL lfsr_pair%0d: got %h want %h", i, obs_pairs[i], exp_pairs[i]); end
    end
    checks++; if (err_sum !== 48'(exp_sum) || samples_done !== 32'd6) begin errors++;
      $display("FAIL lfsr_metrics: sum %0d samples %0d want %0d 6", err_sum, samples_done, exp_sum); end
  endtask

  task automatic test_wrap;
    kind = K_EXACT;
    do_sweep(1'b0, 32'hFFFF_FFFF, 2, -1, -1);
    checks++; if (obs_pairs[0] !== 32'hFFFF_FFFF || obs_pairs[1] !== 32'd0) begin errors++;
      $display("FAIL wrap_pairs: got %h %h want ffffffff 00000000", obs_pairs[0], obs_pairs[1]); end
    checks++; if (samples_done !== 32'd2 || err_cnt !== 32'd0) begin errors++;
      $display("FAIL wrap_metrics: samples %0d cnt %0d want 2 0", samples_done, err_cnt); end
  endtask

  task automatic test_abort;
    kind = K_PLUS1;
    do_sweep(1'b0, 32'd0, 100, 6, -1);
    checks++; if (obs_done_pulses !== 0) begin errors++;
      $display("FAIL abort_no_done: got %0d pulses want 0", obs_done_pulses); end
    checks++; if (samples_done !== 32'd4 || err_sum !== 48'd4 || err_cnt !== 32'd4 || err_max !== 17'd1) begin errors++;
      $display("FAIL abort_partial: samples %0d sum %0d cnt %0d max %0d want 4 4 4 1", samples_done, err_sum, err_cnt, err_max); end
    checks++; if (obs_busy_fall !== 6 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_busy: fall %0d busy %b want 6 0", obs_busy_fall, busy); end
    @(negedge clk);
    mode = 1'b0; seed = 32'd0; num_samples = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({err_sum, err_max, err_cnt, samples_done} !== 129'd0 || busy !== 1'b1) begin errors++;
      $display("FAIL abort_restart_clear: got %h busy %b want 0 busy 1", {err_sum, err_max, err_cnt, samples_done}, busy); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ignored_controls;
    kind = K_PLUS1;
    model_run(1'b0, 32'h0000_0100, 5, K_PLUS1, CAP48);
    do_sweep(1'b0, 32'h0000_0100, 5, -1, 2);
    checks++; if (obs_done_edge !== 7 || obs_done_pulses !== 1) begin errors++;
      $display("FAIL busy_start_done: edge %0d pulses %0d want 7 1", obs_done_edge, obs_done_pulses); end
    checks++; if (err_sum !== 48'(exp_sum) || samples_done !== 32'd5) begin errors++;
      $display("FAIL busy_start_metrics: sum %0d samples %0d want %0d 5", err_sum, samples_done, exp_sum); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err_sum !== 48'd5 || samples_done !== 32'd5) begin errors++;
      $display("FAIL idle_abort_hold: busy %b done %b sum %0d samples %0d want 0 0 5 5", busy, done, err_sum, samples_done); end
  endtask

  task automatic test_reset_mid;
    kind = K_PLUS1;
    @(negedge clk);
    mode = 1'b0; seed = 32'h0000_0040; num_samples = 32'd50; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({op_a, op_b, busy, done} !== 34'd0 || {err_sum, err_max, err_cnt, samples_done} !== 129'd0) begin errors++;
      $display("FAIL reset_mid: ops %h flags %b%b results %h want all 0", {op_b, op_a}, busy, done, {err_sum, err_max, err_cnt, samples_done}); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || samples_done !== 32'd0) begin errors++;
      $display("FAIL reset_mid_idle: busy %b samples %0d want 0 0", busy, samples_done); end
  endtask

  task automatic test_saturate;
    kind = K_EXACT;
    do_sweep(1'b0, 32'd0, 2, -1, -1);
    checks++; if (err_sum2 !== 4'd15) begin errors++;
      $display("FAIL sat_sum: got %0d want 15", err_sum2); end
    checks++; if (err_max2 !== 17'h1FFFF || err_cnt2 !== 32'd2 || samples_done2 !== 32'd2) begin errors++;
      $display("FAIL sat_others: max %h cnt %0d samples %0d want 1ffff 2 2", err_max2, err_cnt2, samples_done2); end
    checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || {op_b2, op_a2} !== 32'd1) begin errors++;
      $display("FAIL sat_idle: busy %b done %b ops %h want 0 0 00000001", busy2, done2, {op_b2, op_a2}); end
  endtask

  task automatic test_random;
    logic        m;
    logic [31:0] s;
    int          n, k;
    for (int it = 0; it < 12; it++) begin
      m = 1'($urandom_range(0, 1));
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'd0;
      n = $urandom_range(1, 24);
      k = $urandom_range(0, 2);
      kind = k;
      model_run(m, s, n, k, CAP48);
      do_sweep(m, s, n, -1, -1);
      checks++; if (err_sum !== 48'(exp_sum) || err_max !== 17'(exp_max) || err_cnt !== 32'(exp_cnt)) begin errors++;
        $display("FAIL rand%0d_metrics: got %0d/%0d/%0d want %0d/%0d/%0d", it, err_sum, err_max, err_cnt, exp_sum, exp_max, exp_cnt); end
      checks++; if (samples_done !== 32'(n) || obs_done_edge !== n + 2) begin errors++;
        $display("FAIL rand%0d_timing: samples %0d done_edge %0d want %0d %0d", it, samples_done, obs_done_edge, n, n + 2); end
      for (int i = 0; i < n; i++) begin
        checks++; if (obs_pairs[i] !== exp_pairs[i]) begin errors++;
          $display("FAIL rand%0d_pair%0d: got %h want %h", it, i, obs_pairs[i], exp_pairs[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_sweep();
    test_approx();
    test_zero_samples();
    test_lfsr();
    test_wrap();
    test_abort();
    test_ignored_controls();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
